peripheral_sqrt_mmio: RTL and testbench

// - Memory-mapped integer square-root peripheral on the CPU bus: registers for operand A, INIT, RESULT and DONE.
// - Computes floor(sqrt(A)) of an unsigned WIDTH-bit operand with an internal iterative core (one root bit per clock).
// - Sits behind the SoC address decoder: cs selects it and addr[4:0] is the byte offset.

---
 rtl/peripheral_sqrt_mmio.sv | 127 ++++++++++++
 tb/tb_peripheral_sqrt_mmio.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_sqrt_mmio.sv
// Memory-mapped integer square-root peripheral: A / INIT / RESULT / DONE registers
// around a restoring digit-by-digit core that produces one root bit per clock.
module peripheral_sqrt_mmio #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d_in,
   input  logic             cs,
   input  logic [4:0]       addr,
   input  logic             rd,
   input  logic             wr,
   output logic [31:0]      d_out
);

   localparam int unsigned RW = WIDTH / 2;
   localparam int unsigned CW = $clog2(RW + 1);
   localparam int unsigned DW = 32;

   localparam logic [2:0] REG_A      = 3'd1;
   localparam logic [2:0] REG_INIT   = 3'd3;
   localparam logic [2:0] REG_RESULT = 3'd4;
   localparam logic [2:0] REG_DONE   = 3'd5;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      CALC    = 2'd2,
      DONE_ST = 2'd3
   } state_t;

   state_t          r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_op;
   logic [RW+1:0]    r_rem;
   logic [RW-1:0]    r_root;
   logic [RW-1:0]    r_result;
   logic [CW-1:0]    r_count;
   logic             r_done;
   logic [DW-1:0]    r_dout;

   logic             w_rd;
   logic             w_wr;
   logic [2:0]       w_reg;
   logic             w_start;
   logic [RW+1:0]    w_rem_sh;
   logic [RW+1:0]    w_trial;
   logic             w_ge;
   logic             w_done_nxt;
   logic [RW-1:0]    w_result_nxt;
   logic [DW-1:0]    w_rdata;
   logic             w_unused;

   // Bus decode; a simultaneous read and write is treated as a read only.
   assign w_rd    = cs & rd;
   assign w_wr    = cs & wr & ~rd;
   assign w_reg   = addr[4:2];
   assign w_start = w_wr && (w_reg == REG_INIT) && d_in[0];

   // One restoring step: bring down two operand bits and try subtracting {root, 01}.
   assign w_rem_sh = {r_rem[RW-1:0], r_op[WIDTH-1 -: 2]};
   assign w_trial  = {r_root, 2'b01};
   assign w_ge     = (w_rem_sh >= w_trial);

   // Status values as they stand after this edge, so a read sees the update it coincides with.
   assign w_done_nxt   = (r_state == DONE_ST) ? 1'b1 :
                         (r_state == LOAD)    ? 1'b0 : r_done;
   assign w_result_nxt = (r_state == DONE_ST) ? r_root : r_result;

   always_comb begin
      w_rdata = '0;
      case (w_reg)
         REG_A:      w_rdata = DW'(r_a);
         REG_RESULT: w_rdata = DW'(w_result_nxt);
         REG_DONE:   w_rdata = DW'(w_done_nxt);
         default:    w_rdata = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_a      <= '0;
         r_op     <= '0;
         r_rem    <= '0;
         r_root   <= '0;
         r_result <= '0;
         r_count  <= '0;
         r_done   <= 1'b0;
         r_dout   <= '0;
      end else begin
         if (w_wr && (w_reg == REG_A)) r_a <= d_in;
         r_dout   <= w_rd ? w_rdata : '0;
         r_done   <= w_done_nxt;
         r_result <= w_result_nxt;
         case (r_state)
            IDLE: begin
               if (w_start) r_state <= LOAD;
            end
            LOAD: begin
               r_op    <= r_a;
               r_rem   <= '0;
               r_root  <= '0;
               r_count <= CW'(RW);
               r_state <= CALC;
            end
            CALC: begin
               r_op    <= {r_op[WIDTH-3:0], 2'b00};
               r_rem   <= w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
               r_root  <= {r_root[RW-2:0], w_ge};
               r_count <= r_count - CW'(1);
               if (r_count == CW'(1)) r_state <= DONE_ST;
            end
            DONE_ST: begin
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // The remainder never exceeds 2*root, so its top bits are never shifted up.
   assign w_unused = ^{addr[1:0], r_rem[RW+1:RW]};

   assign d_out = r_dout;

endmodule

// File: tb/tb_peripheral_sqrt_mmio.sv
// Bench for peripheral_sqrt_mmio: edge-level behavioural model plus directed literal checks
// and a randomized bus phase.
module tb_peripheral_sqrt_mmio;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] d_in;
   logic        cs;
   logic [4:0]  addr;
   logic        rd;
   logic        wr;
   logic [31:0] d_out;

   int n_chk  = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   // Behavioural model state
   int          m_a, m_result, m_pend;
   bit          m_done, m_busy, was_busy;
   int          edge_n, m_load_edge, m_fin_edge;
   logic [31:0] exp_dout;

   peripheral_sqrt_mmio #(.WIDTH(16)) dut (
      .clk   (clk),
      .reset (reset),
      .d_in  (d_in),
      .cs    (cs),
      .addr  (addr),
      .rd    (rd),
      .wr    (wr),
      .d_out (d_out)
   );

   always #5 clk = ~clk;

   function automatic int isqrt(input int a);
      int r = 0;
      while ((r + 1) * (r + 1) <= a) r++;
      return r;
   endfunction

   // Model: INIT accepted at edge N -> operand latched at N+1, RESULT/DONE valid at N+10.
   always @(posedge clk) begin
      if (!reset) begin
         m_a = 0; m_result = 0; m_pend = 0; m_done = 0; m_busy = 0;
         edge_n = 0; m_load_edge = 0; m_fin_edge = 0; exp_dout = '0;
      end else begin
         edge_n++;
         was_busy = m_busy;
         if (m_busy && edge_n == m_load_edge) begin
            m_done = 0;
            m_pend = isqrt(m_a);
         end
         if (m_busy && edge_n == m_fin_edge) begin
            m_result = m_pend;
            m_done   = 1;
            m_busy   = 0;
         end
         exp_dout = '0;
         if (cs && rd) begin
            case (addr[4:2])
               3'd1:    exp_dout = 32'(m_a);
               3'd4:    exp_dout = 32'(m_result);
               3'd5:    exp_dout = 32'(m_done);
               default: exp_dout = '0;
            endcase
         end else if (cs && wr) begin
            if (addr[4:2] == 3'd1) m_a = int'(d_in);
            if (addr[4:2] == 3'd3 && d_in[0] && !was_busy) begin
               m_busy      = 1;
               m_load_edge = edge_n + 1;
               m_fin_edge  = edge_n + 10;
            end
         end
      end
   end

   // Compare DUT read data against the model on every cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         n_chk++;
         if (d_out === exp_dout) n_pass++;
         else $display("FAIL model_cmp t=%0t d_out=%h expected=%h", $time, d_out, exp_dout);
      end
   end

   task automatic lit(input string nm, input logic [31:0] exp);
      n_chk++;
      if (d_out === exp) n_pass++;
      else $display("FAIL %s d_out=%h expected=%h", nm, d_out, exp);
   endtask

   task automatic bus(input logic c, input logic r, input logic w,
                      input logic [4:0] a, input logic [15:0] d);
      @(negedge clk);
      cs = c; rd = r; wr = w; addr = a; d_in = d;
   endtask

   task automatic idle();
      bus(1'b0, 1'b0, 1'b0, 5'h00, 16'h0000);
   endtask

   task automatic rdchk(input logic [4:0] a, input logic [31:0] exp, input string nm);
      bus(1'b1, 1'b1, 1'b0, a, 16'h0000);
      @(negedge clk);
      lit(nm, exp);
      cs = 1'b0; rd = 1'b0; wr = 1'b0;
   endtask

   task automatic run_sqrt(input logic [15:0] a, input logic [31:0] exp, input string nm);
      bus(1'b1, 1'b0, 1'b1, 5'h04, a);
      bus(1'b1, 1'b0, 1'b1, 5'h0C, 16'h0001);
      repeat (11) idle();
      rdchk(5'h10, exp, nm);
      rdchk(5'h14, 32'h1, {nm, "_done"});
   endtask

   logic [4:0] addr_tab [8];

   initial begin
      addr_tab = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h18, 5'h1C};
      reset = 1'b0; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; d_in = '0;
      chk_en = 1'b1;
      repeat (3) @(negedge clk);
      lit("reset_dout", 32'h0);
      #2 reset = 1'b1;

      // Canonical run with exact DONE polling; INIT write lands at edge N.
      bus(1'b1, 1'b0, 1'b1, 5'h04, 16'h0441);
      bus(1'b1, 1'b0, 1'b1, 5'h0C, 16'h0001);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k > 1) lit($sformatf("poll_done_edge_N+%0d", k - 1), (k - 1 >= 10) ? 32'h1 : 32'h0);
         if (k <= 11) begin
            cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = 5'h14; d_in = '0;
         end else begin
            cs = 1'b0; rd = 1'b0;
         end
      end
      rdchk(5'h10, 32'h21, "result_0441");
      rdchk(5'h04, 32'h0441, "readback_a");
      rdchk(5'h00, 32'h0, "unmapped_00");
      rdchk(5'h08, 32'h0, "unmapped_08");
      rdchk(5'h18, 32'h0, "unmapped_18");
      @(negedge clk);
      lit("no_read_zero", 32'h0);

      // Writes to read-only RESULT and INIT with bit0=0 change nothing.
      bus(1'b1, 1'b0, 1'b1, 5'h10, 16'hFFFF);
      bus(1'b1, 1'b0, 1'b1, 5'h0C, 16'hFFFE);
      rdchk(5'h10, 32'h21, "ro_result");
      rdchk(5'h14, 32'h1, "init_bit0_clear_no_start");
      // Read wins over write when both strobes are set.
      bus(1'b1, 1'b1, 1'b1, 5'h04, 16'h1234);
      rdchk(5'h04, 32'h0441, "rd_wr_is_read");

      run_sqrt(16'h0000, 32'h00, "result_0000");
      run_sqrt(16'hFFFF, 32'hFF, "result_FFFF");
      run_sqrt(16'h0440, 32'h20, "result_0440");

      // Busy: DONE cleared on LOAD, A rewrite and a second INIT must not disturb the run.
      bus(1'b1, 1'b0, 1'b1, 5'h04, 16'h0441);
      bus(1'b1, 1'b0, 1'b1, 5'h0C, 16'h0001);
      bus(1'b1, 1'b1, 1'b0, 5'h14, 16'h0000);
      bus(1'b1, 1'b0, 1'b1, 5'h04, 16'hFFFF);
      @(negedge clk);
      lit("done_cleared_on_load", 32'h0);
      cs = 1'b1; rd = 1'b0; wr = 1'b1; addr = 5'h0C; d_in = 16'h0001;
      repeat (7) idle();
      rdchk(5'h14, 32'h1, "busy_done_no_restart");
      rdchk(5'h10, 32'h21, "busy_latched_operand");
      rdchk(5'h04, 32'hFFFF, "busy_a_updated");

      // Reset during CALC cycle 4 aborts the run.
      bus(1'b1, 1'b0, 1'b1, 5'h04, 16'h0441);
      bus(1'b1, 1'b0, 1'b1, 5'h0C, 16'h0001);
      bus(1'b1, 1'b1, 1'b0, 5'h14, 16'h0000);
      repeat (4) idle();
      @(negedge clk);
      #2 reset = 1'b0;
      #1 lit("midrun_reset_dout", 32'h0);
      @(negedge clk);
      #2 reset = 1'b1;
      rdchk(5'h14, 32'h0, "midrun_reset_done");
      rdchk(5'h10, 32'h0, "midrun_reset_result");
      rdchk(5'h04, 32'h0, "midrun_reset_a");
      run_sqrt(16'h0441, 32'h21, "after_reset_run");

      // Randomized bus traffic checked by the model.
      for (int i = 0; i < 3000; i++) begin
         logic [4:0]  ra;
         logic [15:0] rdat;
         ra   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : addr_tab[$urandom_range(0, 7)];
         rdat = 16'($urandom);
         if ($urandom_range(0, 3) == 0) rdat[0] = 1'b1;
         if ($urandom_range(0, 2) == 0)
            idle();
         else
            bus($urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom), ra, rdat);
      end
      idle();
      @(negedge clk);
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
